note_follower: RTL and testbench

- Score-following stage that sits directly downstream of the note filter.
- Consumes the thresholded 12-bit one-hot detected note and compares it against the expected note of the current song position.
- Advances through the song on each held, correct note and counts hits and misses.
- Drives the song index that the staff renderer and the song table lookup use to highlight and fetch the current note.

---
 rtl/note_follower.sv | 169 ++++++++++++++++
 tb/tb_note_follower.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/note_follower.sv
// Score follower: matches the filtered one-hot note against the expected song note,
// advances on held hits and counts hits/misses. Optional per-note timeout: NOTE_FOLLOWER_TIMEOUT_EN.
module note_follower #(
  parameter int note_count     = 62,
  parameter int w_note         = 12,
  parameter int w_idx          = $clog2(note_count),
  parameter int hold_cycles    = 1000,
  parameter int w_score        = 8,
  parameter int timeout_cycles = 100_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [w_note-1:0]  note,
  input  logic [w_note-1:0]  exp_note,
  output logic [w_idx-1:0]   song_idx,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [w_score-1:0] hit_count,
  output logic [w_score-1:0] miss_count,
  output logic               listening,
  output logic               done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LISTEN = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int              w_hold    = (hold_cycles > 1) ? $clog2(hold_cycles) : 1;
  localparam logic [w_hold-1:0] hold_last = w_hold'(hold_cycles - 1);
  localparam logic [w_idx-1:0]  idx_last  = w_idx'(note_count - 1);

  logic [1:0]        state;
  logic              armed;
  logic [w_note-1:0] last_note;
  logic [w_hold-1:0] hold_cnt;

  logic              onehot;
  logic [w_note-1:0] vnote;
  logic              match;
  logic              rearm;
  logic              active;
  logic              timeout;

  // Zero and multi-hot codes both collapse to "no note".
  assign onehot = (note != '0) && ((note & (note - 1'b1)) == '0);
  assign vnote  = onehot ? note : '0;
  assign match  = (vnote != '0) && (vnote == exp_note);
  assign rearm  = (vnote == '0) || (vnote != last_note);
  assign active = (state == LISTEN) || (state == HOLD);

  assign listening = active;

`ifdef NOTE_FOLLOWER_TIMEOUT_EN
  localparam int            w_to    = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  localparam logic [w_to-1:0] to_last = w_to'(timeout_cycles - 1);

  logic [w_to-1:0] to_cnt;
  logic            hold_done;

  assign timeout   = active && (to_cnt == to_last);
  assign hold_done = (state == HOLD) && match && (hold_cnt == hold_last);

  // Per-note budget; restarts whenever the song position moves on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      to_cnt <= '0;
    else if (start || !active || hold_done || timeout)
      to_cnt <= '0;
    else
      to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      song_idx   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      done       <= 1'b0;
      armed      <= 1'b1;
      last_note  <= '0;
      hold_cnt   <= '0;
    end else begin
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      if (start) begin
        state      <= LISTEN;
        song_idx   <= '0;
        hit_count  <= '0;
        miss_count <= '0;
        done       <= 1'b0;
        armed      <= 1'b1;
        last_note  <= '0;
        hold_cnt   <= '0;
      end else begin
        // Release or a change of note re-enables onset detection; explicit
        // clears below take priority within the same cycle.
        if (rearm)
          armed <= 1'b1;

        if (active && timeout) begin
          miss_pulse <= 1'b1;
          if (!(&miss_count))
            miss_count <= miss_count + 1'b1;
          armed    <= 1'b1;
          hold_cnt <= '0;
          if (song_idx == idx_last) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            song_idx <= song_idx + 1'b1;
            state    <= LISTEN;
          end
        end else begin
          case (state)
            LISTEN: begin
              if (armed && (vnote != '0)) begin
                last_note <= vnote;
                if (match) begin
                  state    <= HOLD;
                  hold_cnt <= '0;
                end else begin
                  miss_pulse <= 1'b1;
                  if (!(&miss_count))
                    miss_count <= miss_count + 1'b1;
                  armed <= 1'b0;
                end
              end
            end
            HOLD: begin
              if (match) begin
                if (hold_cnt == hold_last) begin
                  hit_pulse <= 1'b1;
                  if (!(&hit_count))
                    hit_count <= hit_count + 1'b1;
                  armed    <= 1'b0;
                  hold_cnt <= '0;
                  if (song_idx == idx_last) begin
                    state <= DONE;
                    done  <= 1'b1;
                  end else begin
                    song_idx <= song_idx + 1'b1;
                    state    <= LISTEN;
                  end
                end else begin
                  hold_cnt <= hold_cnt + 1'b1;
                end
              end else begin
                // Broken hold: no penalty, the new note is judged next cycle.
                state    <= LISTEN;
                armed    <= 1'b1;
                hold_cnt <= '0;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_note_follower.sv
// Scoreboard bench for note_follower: song E,G,G,C with a 4-cycle hold.
module tb_note_follower;
  localparam int NC = 4, WN = 12, WI = 2, HC = 4, WS = 3, TO = 20;

  localparam logic [WN-1:0] N_C = 12'h800;
  localparam logic [WN-1:0] N_D = 12'h200;
  localparam logic [WN-1:0] N_E = 12'h080;
  localparam logic [WN-1:0] N_G = 12'h010;
  localparam logic [WN-1:0] N_MULTI = 12'h801;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [WN-1:0] note = '0;
  logic [WN-1:0] exp_note;
  logic [WI-1:0] song_idx;
  logic          hit_pulse, miss_pulse, listening, done;
  logic [WS-1:0] hit_count, miss_count;

  note_follower #(
    .note_count(NC), .w_note(WN), .w_idx(WI), .hold_cycles(HC),
    .w_score(WS), .timeout_cycles(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .note(note), .exp_note(exp_note),
    .song_idx(song_idx), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .hit_count(hit_count), .miss_count(miss_count),
    .listening(listening), .done(done)
  );

  // Combinational song table
  always_comb begin
    case (song_idx)
      2'd0:    exp_note = N_E;
      2'd1:    exp_note = N_G;
      2'd2:    exp_note = N_G;
      default: exp_note = N_C;
    endcase
  end

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0, fails = 0;

  typedef struct {
    logic [1:0] kind;   // {hit, miss}
    int         at;
    int         idx;
    int         hits;
    int         misses;
  } ev_t;
  ev_t exp_q[$];

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input bit is_hit, input int dly, input int idx,
                           input int hits, input int misses);
    ev_t e;
    e.kind   = is_hit ? 2'b10 : 2'b01;
    e.at     = cyc + dly;
    e.idx    = idx;
    e.hits   = hits;
    e.misses = misses;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (rst && (hit_pulse || miss_pulse)) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: hit=%0b miss=%0b at cycle %0d, none expected",
                 hit_pulse, miss_pulse, cyc);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("pulse_kind", int'({hit_pulse, miss_pulse}), int'(e.kind));
        chk("pulse_cycle", cyc, e.at);
        chk("pulse_song_idx", int'(song_idx), e.idx);
        chk("pulse_hit_count", int'(hit_count), e.hits);
        chk("pulse_miss_count", int'(miss_count), e.misses);
      end
    end
  end

  task automatic apply(input logic [WN-1:0] v, input int n);
    repeat (n) begin
      note = v;
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_song_idx", int'(song_idx), 0);
    chk("rst_hit_count", int'(hit_count), 0);
    chk("rst_miss_count", int'(miss_count), 0);
    chk("rst_hit_pulse", int'(hit_pulse), 0);
    chk("rst_miss_pulse", int'(miss_pulse), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_listening", int'(listening), 0);
    rst = 1'b1;

`ifndef NOTE_FOLLOWER_TIMEOUT_EN
    // IDLE ignores notes
    apply(N_E, 3);
    chk("idle_listening", int'(listening), 0);
    chk("idle_miss_count", int'(miss_count), 0);
    apply('0, 1);
    pulse_start();
    chk("start_listening", int'(listening), 1);
    chk("start_song_idx", int'(song_idx), 0);

    // idx0 E held 5 cycles -> hit
    expect_ev(1'b1, HC + 1, 1, 1, 0);
    apply(N_E, 5);
    apply('0, 2);
    chk("e_song_idx", int'(song_idx), 1);
    chk("e_hit_count", int'(hit_count), 1);

    // idx1 wrong note D for 3 cycles -> exactly one miss
    expect_ev(1'b0, 1, 1, 1, 1);
    apply(N_D, 3);
    apply('0, 1);
    chk("d_miss_count", int'(miss_count), 1);
    chk("d_song_idx", int'(song_idx), 1);

    // idx1 G -> hit, then keep G held into idx2 (repeated note, not armed)
    expect_ev(1'b1, HC + 1, 2, 2, 1);
    apply(N_G, 5);
    apply(N_G, 6);
    chk("g_held_song_idx", int'(song_idx), 2);
    chk("g_held_hit_count", int'(hit_count), 2);
    apply('0, 1);
    expect_ev(1'b1, HC + 1, 3, 3, 1);
    apply(N_G, 5);
    apply('0, 1);
    chk("g2_song_idx", int'(song_idx), 3);

    // idx3 short C burst then a full hold -> final hit, DONE
    apply(N_C, 2);
    apply('0, 1);
    expect_ev(1'b1, HC + 1, 3, 4, 1);
    apply(N_C, 5);
    chk("c_done", int'(done), 1);
    chk("c_song_idx", int'(song_idx), 3);
    chk("c_listening", int'(listening), 0);
    chk("c_hit_count", int'(hit_count), 4);

    // DONE ignores notes
    apply(N_D, 3);
    apply('0, 1);
    apply(N_C, 5);
    chk("done_miss_count", int'(miss_count), 1);
    chk("done_hit_count", int'(hit_count), 4);
    chk("done_song_idx", int'(song_idx), 3);
    chk("done_hold", int'(done), 1);

    // Restart clears everything
    apply('0, 1);
    pulse_start();
    chk("restart_done", int'(done), 0);
    chk("restart_hit_count", int'(hit_count), 0);
    chk("restart_miss_count", int'(miss_count), 0);
    chk("restart_song_idx", int'(song_idx), 0);

    // Multi-hot is no note: no miss, no hit
    apply(N_MULTI, 6);
    chk("multi_miss_count", int'(miss_count), 0);
    chk("multi_hit_count", int'(hit_count), 0);
    chk("multi_listening", int'(listening), 1);

    // Miss counter saturates at all-ones (7 for 3 bits)
    for (int i = 0; i < 9; i++) begin
      expect_ev(1'b0, 1, 0, 0, (i + 1 > 7) ? 7 : i + 1);
      apply(N_D, 1);
      apply('0, 1);
    end
    chk("sat_miss_count", int'(miss_count), 7);

    // Asynchronous reset in the middle of a hold
    apply(N_E, 3);
    chk("hold_listening", int'(listening), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_song_idx", int'(song_idx), 0);
    chk("async_hit_count", int'(hit_count), 0);
    chk("async_miss_count", int'(miss_count), 0);
    chk("async_hit_pulse", int'(hit_pulse), 0);
    chk("async_miss_pulse", int'(miss_pulse), 0);
    chk("async_done", int'(done), 0);
    chk("async_listening", int'(listening), 0);
    @(negedge clk);
    rst = 1'b1;
    apply(N_E, 6);
    chk("post_rst_idle", int'(listening), 0);
    apply('0, 1);
`else
    // No note at all: the note times out and is skipped as a miss
    apply('0, 1);
    expect_ev(1'b0, TO + 1, 1, 0, 1);
    pulse_start();
    apply('0, 22);
    chk("to_song_idx", int'(song_idx), 1);
    chk("to_miss_count", int'(miss_count), 1);
    chk("to_listening", int'(listening), 1);
`endif

    chk("events_outstanding", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
